// File: rtl/cmp_arbiter_if.sv
// Purpose : request/operand/result bundle shared by the two comparator requesters and cmp_arbiter.
// Latency : none (wires only).
// Backpr. : none; requesters hold req and operands until their ack pulse.
// Ports   : req0/a0/b0 and req1/a1/b1 in; ack0/ack1, grant_id, lt/eq/gt/neq, busy out.
//           With CMP_ARB_STATS_EN defined, cnt0/cnt1 (8-bit completion counters) are added.
// Modports: master = requester side, slave = arbiter side.
interface cmp_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             ack0;
   logic             ack1;
   logic             grant_id;
   logic             lt;
   logic             eq;
   logic             gt;
   logic             neq;
   logic             busy;
`ifdef CMP_ARB_STATS_EN
   logic [7:0]       cnt0;
   logic [7:0]       cnt1;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  ack0, ack1, grant_id, lt, eq, gt, neq, busy, cnt0, cnt1
   );
   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output ack0, ack1, grant_id, lt, eq, gt, neq, busy, cnt0, cnt1
   );
`else
   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  ack0, ack1, grant_id, lt, eq, gt, neq, busy
   );
   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output ack0, ack1, grant_id, lt, eq, gt, neq, busy
   );
`endif
endinterface

// File: rtl/cmp_arbiter.sv
// Purpose : round-robin arbiter + sequencer for one shared signed WIDTH-bit comparator.
// Latency : grant at edge T, flags and one-cycle ack at T+1, idle at T+2; next grant no earlier than T+3.
// Backpr. : requesters hold level req and stable operands until ack; losers simply wait in IDLE.
// Ports   : clk, rst_n (async, active-low); bus (cmp_arbiter_if.slave) carries all requests and results.
// Option  : CMP_ARB_STATS_EN adds 8-bit wrapping completion counters cnt0/cnt1 on the interface.
module cmp_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   cmp_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             grant_q;
   logic             last_grant;
   logic             lt_q;
   logic             eq_q;
   logic             gt_q;
   logic             neq_q;

   logic             any_req;
   logic             win_id;
   logic             grant_now;

   logic [WIDTH-1:0] x;
   logic             carry;
   logic             cmp_lt;
   logic             cmp_eq;

   assign any_req   = bus.req0 | bus.req1;
   // Contested: the requester that did not win last time. Uncontested: whoever asks.
   assign win_id    = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
   assign grant_now = (state == IDLE) & any_req;

   // Subtract-based signed compare on the latched operands. Only the carry out
   // of op_a + ~op_b + 1 is needed, so the difference bits are shifted away.
   assign carry  = 1'(({1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1}) >> WIDTH);
   assign x      = op_a ^ op_b;
   assign cmp_eq = ~|x;
   // Differing signs decide directly; equal signs cannot overflow, so a
   // missing carry (borrow) means op_a < op_b.
   assign cmp_lt = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_a[WIDTH-1] : ~carry;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = EVAL;
         EVAL:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, grant bookkeeping and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a       <= '0;
         op_b       <= '0;
         grant_q    <= 1'b0;
         last_grant <= 1'b1;
         lt_q       <= 1'b0;
         eq_q       <= 1'b0;
         gt_q       <= 1'b0;
         neq_q      <= 1'b0;
      end else begin
         if (grant_now) begin
            op_a       <= win_id ? bus.a1 : bus.a0;
            op_b       <= win_id ? bus.b1 : bus.b0;
            grant_q    <= win_id;
            last_grant <= win_id;
         end
         if (state == EVAL) begin
            lt_q  <= cmp_lt;
            eq_q  <= cmp_eq;
            gt_q  <= ~(cmp_lt | cmp_eq);
            neq_q <= ~cmp_eq;
         end
      end
   end

`ifdef CMP_ARB_STATS_EN
   logic [7:0] cnt0_q;
   logic [7:0] cnt1_q;

   // Counted on the EVAL->RESP edge, i.e. the edge at which ack rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else if (state == EVAL) begin
         if (grant_q) begin
            cnt1_q <= cnt1_q + 8'd1;
         end else begin
            cnt0_q <= cnt0_q + 8'd1;
         end
      end
   end

   assign bus.cnt0 = cnt0_q;
   assign bus.cnt1 = cnt1_q;
`endif

   // Outputs: ack is a decode of the RESP state, so it lasts exactly one cycle
   // and only the granted requester can see it.
   always_comb begin
      bus.ack0     = 1'b0;
      bus.ack1     = 1'b0;
      bus.busy     = (state != IDLE);
      bus.grant_id = grant_q;
      bus.lt       = lt_q;
      bus.eq       = eq_q;
      bus.gt       = gt_q;
      bus.neq      = neq_q;
      if (state == RESP) begin
         bus.ack0 = ~grant_q;
         bus.ack1 = grant_q;
      end
   end

endmodule
